// File: rtl/fault_mem_pkg.sv
// Shared fault-type codes and the fault-slot record used by the fault memory.
package fault_mem_pkg;

  // Widest address / bit-index a slot record can hold; instances zero-extend into these.
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_BIT_W  = 8;

  typedef enum logic [2:0] {
    FT_NONE = 3'd0,
    FT_SA   = 3'd1,
    FT_TF   = 3'd2,
    FT_CFID = 3'd3,
    FT_NPSF = 3'd4
  } fault_e;

  typedef struct packed {
    fault_e                ftype;
    logic                  pol;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_ADDR_W-1:0] aggr_addr;
    logic [MAX_BIT_W-1:0]  bit_idx;
    logic [MAX_BIT_W-1:0]  aggr_bit;
  } slot_t;

  localparam slot_t SLOT_NONE = '{ftype: FT_NONE, pol: 1'b0, addr: '0,
                                  aggr_addr: '0, bit_idx: '0, aggr_bit: '0};

  // Unused type codes 5-7 behave as an empty slot.
  function automatic fault_e decode_type(input logic [2:0] code);
    case (code)
      3'd1:    return FT_SA;
      3'd2:    return FT_TF;
      3'd3:    return FT_CFID;
      3'd4:    return FT_NPSF;
      default: return FT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fault_table.sv
// Fault slot registers plus the per-access fault application for the word
// being accessed in stage 2. Slots are applied in ascending index order so a
// higher slot overrides a lower one on the same bit.
module fault_table
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_FAULTS = 4,
  parameter int IDX_W      = 2,
  parameter int BIT_W      = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_we,
  input  logic [IDX_W-1:0]                       cfg_idx,
  input  logic [2:0]                             cfg_type,
  input  logic [ADDR_WIDTH-1:0]                  cfg_addr,
  input  logic [ADDR_WIDTH-1:0]                  cfg_aggr_addr,
  input  logic [BIT_W-1:0]                       cfg_bit,
  input  logic [BIT_W-1:0]                       cfg_aggr_bit,
  input  logic                                   cfg_pol,
  input  logic                                   acc_write,
  input  logic [ADDR_WIDTH-1:0]                  acc_addr,
  input  logic [DATA_WIDTH-1:0]                  wdata,
  input  logic [DATA_WIDTH-1:0]                  old_word,
  input  logic [DATA_WIDTH-1:0]                  up_word,
  input  logic [DATA_WIDTH-1:0]                  dn_word,
  output logic [DATA_WIDTH-1:0]                  wr_word,
  output logic [DATA_WIDTH-1:0]                  rd_word,
  output logic [NUM_FAULTS-1:0]                  force_en,
  output logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0]  force_addr,
  output logic [NUM_FAULTS-1:0][DATA_WIDTH-1:0]  force_mask,
  output logic [NUM_FAULTS-1:0]                  force_pol
);

  slot_t slots [NUM_FAULTS];

  logic [NUM_FAULTS-1:0][DATA_WIDTH-1:0] vmask;
  logic [NUM_FAULTS-1:0][DATA_WIDTH-1:0] amask;
  logic [NUM_FAULTS-1:0]                 vhit;
  logic [NUM_FAULTS-1:0]                 cfid_trig;
  logic [NUM_FAULTS-1:0]                 npsf_act;
  logic                                  not_edge;

  function automatic logic [DATA_WIDTH-1:0] apply_bits(input logic [DATA_WIDTH-1:0] w,
                                                       input logic [DATA_WIDTH-1:0] m,
                                                       input logic p);
    return p ? (w | m) : (w & ~m);
  endfunction

  // Slot storage: reset empties every slot, otherwise cfg_we loads the indexed slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (rst) begin
        slots[i] <= SLOT_NONE;
      end else if (cfg_we && (cfg_idx == IDX_W'(i))) begin
        slots[i] <= '{ftype: decode_type(cfg_type), pol: cfg_pol,
                      addr: MAX_ADDR_W'(cfg_addr), aggr_addr: MAX_ADDR_W'(cfg_aggr_addr),
                      bit_idx: MAX_BIT_W'(cfg_bit), aggr_bit: MAX_BIT_W'(cfg_aggr_bit)};
      end
    end
  end

  // Per-slot decode: bit masks, victim hit, CFID aggressor transition, NPSF neighbourhood.
  always_comb begin
    not_edge = (acc_addr != '0) && (acc_addr != '1);
    for (int i = 0; i < NUM_FAULTS; i++) begin
      vmask[i]     = DATA_WIDTH'(1) << slots[i].bit_idx;
      amask[i]     = DATA_WIDTH'(1) << slots[i].aggr_bit;
      vhit[i]      = (acc_addr == ADDR_WIDTH'(slots[i].addr));
      cfid_trig[i] = (slots[i].ftype == FT_CFID) && acc_write &&
                     (acc_addr == ADDR_WIDTH'(slots[i].aggr_addr)) &&
                     ((|(old_word & amask[i])) != slots[i].pol) &&
                     ((|(wdata & amask[i])) == slots[i].pol);
      npsf_act[i]  = (slots[i].ftype == FT_NPSF) && vhit[i] && not_edge &&
                     ((|(up_word & vmask[i])) == slots[i].pol) &&
                     ((|(dn_word & vmask[i])) == slots[i].pol);
      // A CFID victim that is the word being written is folded into wr_word instead.
      force_en[i]   = cfid_trig[i] && !vhit[i];
      force_addr[i] = ADDR_WIDTH'(slots[i].addr);
      force_mask[i] = vmask[i];
      force_pol[i]  = slots[i].pol;
    end
  end

  // Fault application on the written word and read masking, lowest slot first.
  always_comb begin
    wr_word = wdata;
    rd_word = old_word;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      case (slots[i].ftype)
        FT_SA: begin
          if (vhit[i]) begin
            wr_word = apply_bits(wr_word, vmask[i], slots[i].pol);
            rd_word = apply_bits(rd_word, vmask[i], slots[i].pol);
          end
        end
        FT_TF: begin
          if (vhit[i] && ((|(old_word & vmask[i])) != slots[i].pol) &&
              ((|(wdata & vmask[i])) == slots[i].pol)) begin
            wr_word = (wr_word & ~vmask[i]) | (old_word & vmask[i]);
          end
        end
        FT_CFID: begin
          if (cfid_trig[i] && vhit[i]) begin
            wr_word = apply_bits(wr_word, vmask[i], slots[i].pol);
          end
        end
        FT_NPSF: begin
          if (npsf_act[i]) begin
            wr_word = apply_bits(wr_word, vmask[i], !slots[i].pol);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_fault_mem.sv
// Single-port memory with runtime-programmable fault injection.
// Access protocol: en is a one-cycle request strobe (no backpressure, one
// access per cycle); write_read/address/wdata are qualified by en. A read
// returns rdata with a one-cycle rd_valid pulse two edges after the edge that
// sampled the request. Writes produce no response.
module prog_fault_mem
  import fault_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_FAULTS = 4,
  localparam int IDX_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1,
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write_read,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [2:0]            cfg_type,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_aggr_addr,
  input  logic [BIT_W-1:0]      cfg_bit,
  input  logic [BIT_W-1:0]      cfg_aggr_bit,
  input  logic                  cfg_pol
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  s1_valid;
  logic                  s1_wr;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_wdata;
  logic                  s2_rd_valid;
  logic [DATA_WIDTH-1:0] s2_data;

  logic [ADDR_WIDTH-1:0] up_addr;
  logic [ADDR_WIDTH-1:0] dn_addr;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [NUM_FAULTS-1:0]                 force_en;
  logic [NUM_FAULTS-1:0][ADDR_WIDTH-1:0] force_addr;
  logic [NUM_FAULTS-1:0][DATA_WIDTH-1:0] force_mask;
  logic [NUM_FAULTS-1:0]                 force_pol;

  // Neighbour addresses wrap here; the fault table blocks NPSF at the array ends.
  assign up_addr   = s1_addr + ADDR_WIDTH'(1);
  assign dn_addr   = s1_addr - ADDR_WIDTH'(1);
  assign acc_write = s1_valid && s1_wr && !rst;

  fault_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_FAULTS (NUM_FAULTS),
    .IDX_W      (IDX_W),
    .BIT_W      (BIT_W)
  ) u_fault_table (
    .clk           (clk),
    .rst           (rst),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_type      (cfg_type),
    .cfg_addr      (cfg_addr),
    .cfg_aggr_addr (cfg_aggr_addr),
    .cfg_bit       (cfg_bit),
    .cfg_aggr_bit  (cfg_aggr_bit),
    .cfg_pol       (cfg_pol),
    .acc_write     (acc_write),
    .acc_addr      (s1_addr),
    .wdata         (s1_wdata),
    .old_word      (mem[s1_addr]),
    .up_word       (mem[up_addr]),
    .dn_word       (mem[dn_addr]),
    .wr_word       (wr_word),
    .rd_word       (rd_word),
    .force_en      (force_en),
    .force_addr    (force_addr),
    .force_mask    (force_mask),
    .force_pol     (force_pol)
  );

  // Stage 1 request capture; en is ignored while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= en;
    end
    s1_wr    <= write_read;
    s1_addr  <= address;
    s1_wdata <= wdata;
  end

  // Stage 2 array update: faulted write word plus CFID forcing of other victims.
  always_ff @(posedge clk) begin
    if (acc_write) begin
      mem[s1_addr] <= wr_word;
    end
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (force_en[i] && !rst) begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
          if (force_mask[i][b]) begin
            mem[force_addr[i]][b] <= force_pol[i];
          end
        end
      end
    end
  end

  // Stage 2 read capture and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_rd_valid <= 1'b0;
      s2_data     <= '0;
      rd_valid    <= 1'b0;
      rdata       <= '0;
    end else begin
      s2_rd_valid <= s1_valid && !s1_wr;
      s2_data     <= rd_word;
      rd_valid    <= s2_rd_valid;
      rdata       <= s2_data;
    end
  end

endmodule

// File: tb/tb_prog_fault_mem.sv
// Bench for prog_fault_mem: read expectations queued at issue, checked on rd_valid.
module tb_prog_fault_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       write_read = 1'b0;
  logic [5:0] address = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       rd_valid;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [2:0] cfg_type = '0;
  logic [5:0] cfg_addr = '0;
  logic [5:0] cfg_aggr_addr = '0;
  logic [2:0] cfg_bit = '0;
  logic [2:0] cfg_aggr_bit = '0;
  logic       cfg_pol = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [64];

  prog_fault_mem #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .NUM_FAULTS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .write_read    (write_read),
    .address       (address),
    .wdata         (wdata),
    .rdata         (rdata),
    .rd_valid      (rd_valid),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_type      (cfg_type),
    .cfg_addr      (cfg_addr),
    .cfg_aggr_addr (cfg_aggr_addr),
    .cfg_bit       (cfg_bit),
    .cfg_aggr_bit  (cfg_aggr_bit),
    .cfg_pol       (cfg_pol)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every rd_valid pulse pops one expected word
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: rdata=%h with no read outstanding", rdata);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rdata !== e) begin
          errors++;
          $display("FAIL rdata: got %h expected %h", rdata, e);
        end
      end
    end
  end

  // Driver tasks: all inputs change 1 time unit after a rising edge
  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    en = 1'b1; write_read = 1'b1; address = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; write_read = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] e, input bit expect_it);
    en = 1'b1; write_read = 1'b0; address = a;
    if (expect_it) exp_q.push_back(e);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic set_slot(input logic [1:0] idx, input logic [2:0] typ,
                          input logic [5:0] vaddr, input logic [5:0] aaddr,
                          input logic [2:0] vbit, input logic [2:0] abit, input logic pol);
    cfg_we = 1'b1; cfg_idx = idx; cfg_type = typ; cfg_addr = vaddr;
    cfg_aggr_addr = aaddr; cfg_bit = vbit; cfg_aggr_bit = abit; cfg_pol = pol;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d reads outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    // Requests during reset must be ignored
    en = 1'b1; write_read = 1'b0; address = 6'd0;
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_type = 3'd1; cfg_addr = 6'd0; cfg_bit = 3'd0; cfg_pol = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0; cfg_we = 1'b0;
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_ignored_en: got %b expected 0", rd_valid); end
    // Slot written during reset must not exist: word 0 reads back as written
    do_write(6'd0, 8'h00);
    do_read(6'd0, 8'h00, 1'b1);
    drain("reset");
  endtask

  task automatic test_no_fault();
    do_write(6'd5, 8'hA5);
    do_read(6'd5, 8'hA5, 1'b1);
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL latency_n: rd_valid %b expected 0", rd_valid); end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: rd_valid %b expected 0", rd_valid); end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b1) begin errors++; $display("FAIL latency_n2: rd_valid %b expected 1", rd_valid); end
    drain("no_fault");
  endtask

  task automatic test_random_back_to_back();
    logic [5:0] a;
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      a = 6'($urandom_range(41, 60));
      d = 8'($urandom_range(0, 255));
      ref_mem[a] = d;
      do_write(a, d);
      do_read(a, ref_mem[a], 1'b1);
    end
    for (int i = 41; i <= 60; i++) begin
      if (i % 3 == 0) begin
        d = 8'($urandom_range(0, 255));
        ref_mem[i] = d;
        do_write(6'(i), d);
      end
    end
    for (int i = 41; i <= 60; i++) begin
      if (i % 3 == 0) do_read(6'(i), ref_mem[i], 1'b1);
    end
    drain("random");
  endtask

  task automatic test_sa();
    set_slot(2'd0, 3'd1, 6'd3, 6'd0, 3'd2, 3'd0, 1'b1);
    do_write(6'd3, 8'h00);
    do_read(6'd3, 8'h04, 1'b1);
    do_write(6'd3, 8'hF3);
    do_read(6'd3, 8'hF7, 1'b1);
    drain("sa");
  endtask

  task automatic test_tf();
    set_slot(2'd1, 3'd2, 6'd7, 6'd0, 3'd0, 3'd0, 1'b1);
    do_write(6'd7, 8'h00);
    do_write(6'd7, 8'h01);
    do_read(6'd7, 8'h00, 1'b1);
    do_write(6'd7, 8'hFE);
    do_read(6'd7, 8'hFE, 1'b1);
    drain("tf");
  endtask

  task automatic test_cfid();
    set_slot(2'd2, 3'd3, 6'd12, 6'd10, 3'd7, 3'd1, 1'b1);
    do_write(6'd12, 8'h00);
    do_write(6'd10, 8'h00);
    do_write(6'd10, 8'h02);
    do_read(6'd12, 8'h80, 1'b1);
    do_read(6'd10, 8'h02, 1'b1);
    drain("cfid");
    // Victim equal to the written word: forcing beats the data bit
    set_slot(2'd2, 3'd3, 6'd20, 6'd20, 3'd7, 3'd0, 1'b1);
    do_write(6'd20, 8'h00);
    do_write(6'd20, 8'h01);
    do_read(6'd20, 8'h81, 1'b1);
    drain("cfid_self");
  endtask

  task automatic test_npsf();
    set_slot(2'd3, 3'd4, 6'd9, 6'd0, 3'd5, 3'd0, 1'b1);
    do_write(6'd8, 8'h20);
    do_write(6'd10, 8'h20);
    do_write(6'd9, 8'hFF);
    do_read(6'd9, 8'hDF, 1'b1);
    drain("npsf");
    // Address 0 never activates, even with the wrapped neighbour matching
    set_slot(2'd3, 3'd4, 6'd0, 6'd0, 3'd5, 3'd0, 1'b1);
    do_write(6'd1, 8'h20);
    do_write(6'd63, 8'h20);
    do_write(6'd0, 8'hFF);
    do_read(6'd0, 8'hFF, 1'b1);
    drain("npsf_edge");
  endtask

  task automatic test_priority();
    set_slot(2'd0, 3'd1, 6'd30, 6'd0, 3'd4, 3'd0, 1'b1);
    set_slot(2'd1, 3'd1, 6'd30, 6'd0, 3'd4, 3'd0, 1'b0);
    do_write(6'd30, 8'hFF);
    do_read(6'd30, 8'hEF, 1'b1);
    do_write(6'd30, 8'h00);
    do_read(6'd30, 8'h00, 1'b1);
    // Type codes 5-7 act as an empty slot
    set_slot(2'd1, 3'd6, 6'd30, 6'd0, 3'd4, 3'd0, 1'b0);
    do_write(6'd30, 8'h00);
    do_read(6'd30, 8'h10, 1'b1);
    drain("priority");
  endtask

  task automatic test_reset_midread();
    set_slot(2'd0, 3'd1, 6'd3, 6'd0, 3'd2, 3'd0, 1'b1);
    do_write(6'd3, 8'h00);
    do_write(6'd40, 8'h55);
    // Read in flight when reset arrives: no response
    do_read(6'd3, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL midread_n1: rd_valid %b expected 0", rd_valid); end
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL midread_n2: rd_valid %b expected 0", rd_valid); end
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL midread_rdata: got %h expected 00", rdata); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL midread_n3: rd_valid %b expected 0", rd_valid); end
    // Write in flight when reset arrives is dropped
    do_write(6'd40, 8'hAA);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(6'd40, 8'h55, 1'b1);
    // SA slot cleared by reset
    do_write(6'd3, 8'h00);
    do_read(6'd3, 8'h00, 1'b1);
    drain("midread");
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_random_back_to_back();
    test_sa();
    test_tf();
    test_cfid();
    test_npsf();
    test_priority();
    test_reset_midread();
    repeat (4) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_fault_mem.md
PROG_FAULT_MEM -- requirements
Module: prog_fault_mem

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NUM_FAULTS, default 4, number of runtime-programmable fault slots.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  memory access request strobe.
REQ-007 SHALL have port write_read  input  1  1 = write, 0 = read; sampled with en.
REQ-008 SHALL have port address  input  ADDR_WIDTH  access address.
REQ-009 SHALL have port wdata  input  DATA_WIDTH  write data, sampled with en.
REQ-010 SHALL have port rdata  output  DATA_WIDTH  read data, registered.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rdata.
REQ-012 SHALL have port cfg_we  input  1  fault-slot write strobe.
REQ-013 SHALL have port cfg_idx  input  clog2(NUM_FAULTS)  slot index.
REQ-014 SHALL have port cfg_type  input  3  fault type: 0 NONE, 1 SA, 2 TF, 3 CFID, 4 NPSF; 5-7 treated as NONE.
REQ-015 SHALL have ports cfg_addr/cfg_aggr_addr  input  ADDR_WIDTH each  victim and aggressor address.
REQ-016 SHALL have ports cfg_bit/cfg_aggr_bit  input  clog2(DATA_WIDTH) each  victim and aggressor bit.
REQ-017 SHALL have port cfg_pol  input  1  fault polarity.

Function
REQ-018 SHALL register en, write_read, address, wdata at edge N (stage 1), access array at edge N+1 (stage 2), drive rdata/rd_valid at edge N+2; read latency 2 cycles, one access per cycle, fully pipelined.
REQ-019 Write with no matching active slot SHALL store wdata unchanged.
REQ-020 SA: victim bit SHALL be forced to cfg_pol on every write and masked to cfg_pol on every read of cfg_addr.
REQ-021 TF: a write changing victim bit from ~cfg_pol to cfg_pol SHALL leave the bit unchanged; other bits written normally.
REQ-022 CFID: a write to cfg_aggr_addr changing cfg_aggr_bit from ~cfg_pol to cfg_pol SHALL, at the same edge, force the victim bit of cfg_addr to cfg_pol.
REQ-023 NPSF: a write to cfg_addr with mem[cfg_addr+1][cfg_bit] == mem[cfg_addr-1][cfg_bit] == cfg_pol SHALL store victim bit as ~cfg_pol; at address 0 or 2**ADDR_WIDTH-1 the fault is never active (no wrap).
REQ-024 Multiple active slots SHALL apply in ascending index; higher index wins on the same bit.
REQ-025 CFID whose victim equals the address written in the same cycle: CFID forcing SHALL override the write data bit.
REQ-026 Reads SHALL not alter array contents; reads without SA match return stored word.
REQ-027 cfg write at edge N SHALL affect stage-2 accesses at edge N+1 and later; an access in stage 2 at edge N uses the old slot.
REQ-028 Read-after-write to same address in consecutive cycles SHALL return post-fault written data (no hazard).

Reset
REQ-029 rst SHALL clear all slots to NONE, clear pipeline valids, set rdata = 0, rd_valid = 0 on the next edge.
REQ-030 rst SHALL not initialise the array; an access in flight during rst SHALL be dropped (no write, no rd_valid).
REQ-031 en and cfg_we SHALL be ignored in cycles where rst = 1.

Structure
REQ-032 Fault-type codes and slot record layout SHALL live in shared package fault_mem_pkg.
REQ-033 Slot registers and per-access match logic SHALL be sub-module fault_table; array and pipeline stay in prog_fault_mem.

Verification
REQ-034 No faults: write 0xA5 to addr 5, read addr 5 -> rdata 0xA5, rd_valid 2 cycles after read request.
REQ-035 SA slot0 addr 3 bit 2 pol 1: write 0x00, read -> 0x04.
REQ-036 TF slot1 addr 7 bit 0 pol 1: write 0x00 then 0x01, read -> 0x00; write 0xFE -> read 0xFE.
REQ-037 CFID aggr 10 bit 1 pol 1, victim 12 bit 7: write 0x00 @12, 0x00 then 0x02 @10, read 12 -> 0x80.
REQ-038 NPSF addr 9 bit 5 pol 1: write 0x20 @8 and @10, write 0xFF @9, read -> 0xDF; same at addr 0 -> no fault.
REQ-039 Assert rst mid-read: rd_valid stays 0; slots cleared, SA from REQ-035 inactive afterward.
